ucode_seq: RTL

//  Microcode sequencer for the multiply datapath; sits directly upstream of the micro-PC register.

---
 rtl/ucode_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ucode_seq.sv
// ucode_seq: microcode sequencer sitting in front of the micro-PC register.
// Decodes the sequencing op of the current microinstruction and tells the
// micro-PC register whether to increment or load upc_next on every cycle.
// Holds the IDLE/RUN/DONE run FSM, the LOOP iteration counter and a
// single-level return-address register for CALL/RET.
// The reset input is asynchronous and active-low (reset=0 resets).
// Optional feature macro: USEQ_ABORT_EN adds an 'abort' input that drops a
// running sequence back to IDLE without a done pulse.
module ucode_seq #(
  parameter int UW         = 5,
  parameter int CW         = 8,
  parameter int NCOND      = 4,
  parameter int ITER       = 8,
  parameter int START_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [UW-1:0] upc,
  input  logic [2:0]    seq_op,
  input  logic [1:0]    cond_sel,
  input  logic [UW-1:0] br_addr,
  input  logic [CW-1:0] uctrl,
  input  logic [NCOND-1:0] cond,
`ifdef USEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic          load_incr,
  output logic [UW-1:0] upc_next,
  output logic [CW-1:0] ctrl,
  output logic          busy,
  output logic          done
);

  localparam int CNTW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_BR_T = 3'd2;
  localparam logic [2:0] OP_BR_F = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_LOOP = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [UW-1:0]   START = UW'(START_ADDR);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(ITER - 1);

  logic [1:0]      state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [UW-1:0]   ret, ret_n;
  logic [UW-1:0]   upc_inc;
  logic            flag;

  assign upc_inc = upc + UW'(1);
  assign flag    = cond[cond_sel];

  // Next-state and output decode; outputs respond to the current upc in the same cycle
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ret_n     = ret;
    load_incr = 1'b1;
    upc_next  = START;
    ctrl      = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          cnt_n   = CNT_LOAD;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        ctrl      = uctrl;
        load_incr = 1'b0;
        upc_next  = upc_inc;
        case (seq_op)
          OP_NEXT: ;
          OP_JUMP: begin
            load_incr = 1'b1;
            upc_next  = br_addr;
          end
          OP_BR_T: begin
            if (flag) begin
              load_incr = 1'b1;
              upc_next  = br_addr;
            end
          end
          OP_BR_F: begin
            if (!flag) begin
              load_incr = 1'b1;
              upc_next  = br_addr;
            end
          end
          OP_CALL: begin
            load_incr = 1'b1;
            upc_next  = br_addr;
            ret_n     = upc_inc;
          end
          OP_RET: begin
            load_incr = 1'b1;
            upc_next  = ret;
          end
          OP_LOOP: begin
            if (cnt != '0) begin
              cnt_n     = cnt - CNTW'(1);
              load_incr = 1'b1;
              upc_next  = br_addr;
            end
          end
          OP_HALT: begin
            load_incr = 1'b1;
            upc_next  = START;
            state_n   = ST_DONE;
          end
          default: ;
        endcase
`ifdef USEQ_ABORT_EN
        // Abort overrides whatever the microinstruction asked for
        if (abort) begin
          ctrl      = '0;
          load_incr = 1'b1;
          upc_next  = START;
          state_n   = ST_IDLE;
          cnt_n     = cnt;
          ret_n     = ret;
        end
`endif
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Registered FSM state, loop counter and return address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ret   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ret   <= ret_n;
    end
  end

endmodule
